reg_scan_sequencer: RTL

REG_SCAN_SEQUENCER -- requirements
Module: reg_scan_sequencer

---
 rtl/reg_scan_pkg.sv | 30 +++
 rtl/reg_scan_sequencer_bin2bcd.sv | 53 +++++
 rtl/reg_scan_sequencer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/reg_scan_pkg.sv
// Shared types and constants for the register scan sequencer.
// Optional zero-skip build is selected in the top with REG_SCAN_SKIP_ZERO_EN.
package reg_scan_pkg;

    localparam int unsigned ADDR_W      = 5;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned BIN_W       = 7;
    localparam int unsigned BCD_W       = 4;
    localparam int unsigned CONV_CYCLES = 7;
    localparam int unsigned CONV_CNT_W  = 3;
    localparam int unsigned LCD_TIMEOUT = 4;
    localparam int unsigned WAIT_W      = 2;
    localparam int unsigned DWELL_W     = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_CONVERT,
        S_PRINT,
        S_WAIT_LCD,
        S_DWELL,
        S_NEXT
    } state_t;

    // One double-dabble correction on a single BCD digit.
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] d);
        return (d >= BCD_W'(5)) ? BCD_W'(d + BCD_W'(3)) : d;
    endfunction

endpackage

// File: rtl/reg_scan_sequencer_bin2bcd.sv
// Sequential shift-add-3 converter: 7-bit binary to two BCD digits.
// The first shift is folded into the load, so results are ready 7 cycles after go.
module bin2bcd_seq
    import reg_scan_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [BIN_W-1:0] bin,
    output logic             done,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones,
    output logic             ovf
);

    logic [BIN_W-1:0]     sh;
    logic [2*BCD_W-1:0]   bcd;
    logic [CONV_CNT_W-1:0] cnt;
    logic [BCD_W-1:0]     t_adj;
    logic [BCD_W-1:0]     o_adj;

    always_comb begin
        t_adj = add3(bcd[2*BCD_W-1:BCD_W]);
        o_adj = add3(bcd[BCD_W-1:0]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh   <= '0;
            bcd  <= '0;
            cnt  <= '0;
            done <= 1'b0;
            ovf  <= 1'b0;
        end else if (go) begin
            bcd  <= {(2*BCD_W-1)'(0), bin[BIN_W-1]};
            sh   <= {bin[BIN_W-2:0], 1'b0};
            cnt  <= CONV_CNT_W'(CONV_CYCLES - 1);
            done <= 1'b0;
            ovf  <= (bin > BIN_W'(99));
        end else if (cnt != '0) begin
            bcd  <= {t_adj[BCD_W-2:0], o_adj, sh[BIN_W-1]};
            sh   <= {sh[BIN_W-2:0], 1'b0};
            cnt  <= CONV_CNT_W'(cnt - 1'b1);
            done <= (cnt == CONV_CNT_W'(1));
        end else begin
            done <= 1'b0;
        end
    end

    assign tens = bcd[2*BCD_W-1:BCD_W];
    assign ones = bcd[BCD_W-1:0];

endmodule

// File: rtl/reg_scan_sequencer.sv
// Walks a register file, converts each value to sign + two BCD digits and hands it to an LCD.
// Define REG_SCAN_SKIP_ZERO_EN to skip printing registers that read zero.
module reg_scan_sequencer
    import reg_scan_pkg::*;
#(
    parameter int unsigned NUM_REGS     = 32,
    parameter int unsigned DWELL_CYCLES = 50_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              continuous,
    output logic [ADDR_W-1:0] reg_addr,
    input  logic [DATA_W-1:0] reg_data,
    output logic              lcd_start,
    input  logic              lcd_busy,
    output logic              sign,
    output logic [BCD_W-1:0]  digit1,
    output logic [BCD_W-1:0]  digit2,
    output logic              overflow,
    output logic              busy
);

    state_t               state, next_state;
    logic [ADDR_W-1:0]    nxt_addr;
    logic                 nxt_sign, nxt_ovf, nxt_seen, nxt_cap_sign, nxt_cap_big;
    logic [BCD_W-1:0]     nxt_d1, nxt_d2;
    logic [DWELL_W-1:0]   dwell_cnt, nxt_dwell;
    logic [WAIT_W-1:0]    wait_cnt, nxt_wait;
    logic                 seen, cap_sign, cap_big;
    logic [DATA_W-1:0]    mag;
    logic                 conv_go, conv_done, conv_ovf;
    logic [BCD_W-1:0]     conv_tens, conv_ones;

    // Two's-complement magnitude; 0x80000000 stays 0x80000000 and lands in the overflow path.
    assign mag = reg_data[DATA_W-1] ? DATA_W'(~reg_data + 1'b1) : reg_data;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .go    (conv_go),
        .bin   (mag[BIN_W-1:0]),
        .done  (conv_done),
        .tens  (conv_tens),
        .ones  (conv_ones),
        .ovf   (conv_ovf)
    );

    always_comb begin
        next_state   = state;
        nxt_addr     = reg_addr;
        nxt_sign     = sign;
        nxt_d1       = digit1;
        nxt_d2       = digit2;
        nxt_ovf      = overflow;
        nxt_dwell    = dwell_cnt;
        nxt_wait     = wait_cnt;
        nxt_seen     = seen;
        nxt_cap_sign = cap_sign;
        nxt_cap_big  = cap_big;
        conv_go      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    nxt_addr   = '0;
                    next_state = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                nxt_cap_sign = reg_data[DATA_W-1];
                nxt_cap_big  = |mag[DATA_W-1:BIN_W];
`ifdef REG_SCAN_SKIP_ZERO_EN
                if (reg_data == '0) begin
                    next_state = S_NEXT;
                end else begin
                    conv_go    = 1'b1;
                    next_state = S_CONVERT;
                end
`else
                conv_go    = 1'b1;
                next_state = S_CONVERT;
`endif
            end
            S_CONVERT: begin
                if (conv_done) begin
                    nxt_sign   = cap_sign;
                    nxt_ovf    = cap_big | conv_ovf;
                    nxt_d1     = nxt_ovf ? BCD_W'(9) : conv_tens;
                    nxt_d2     = nxt_ovf ? BCD_W'(9) : conv_ones;
                    next_state = S_PRINT;
                end
            end
            S_PRINT: begin
                nxt_wait   = '0;
                nxt_seen   = 1'b0;
                next_state = S_WAIT_LCD;
            end
            S_WAIT_LCD: begin
                // A busy pulse that never shows up within the window counts as a finished print.
                if (seen) begin
                    if (!lcd_busy) begin
                        nxt_dwell  = '0;
                        next_state = S_DWELL;
                    end
                end else if (lcd_busy) begin
                    nxt_seen = 1'b1;
                end else if (wait_cnt == WAIT_W'(LCD_TIMEOUT - 2)) begin
                    nxt_dwell  = '0;
                    next_state = S_DWELL;
                end else begin
                    nxt_wait = WAIT_W'(wait_cnt + 1'b1);
                end
            end
            S_DWELL: begin
                if (dwell_cnt >= DWELL_W'(DWELL_CYCLES - 1)) begin
                    next_state = S_NEXT;
                end else begin
                    nxt_dwell = DWELL_W'(dwell_cnt + 1'b1);
                end
            end
            S_NEXT: begin
                if (reg_addr < ADDR_W'(NUM_REGS - 1)) begin
                    nxt_addr   = ADDR_W'(reg_addr + 1'b1);
                    next_state = S_CAPTURE;
                end else if (continuous) begin
                    nxt_addr   = '0;
                    next_state = S_CAPTURE;
                end else begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            reg_addr  <= '0;
            lcd_start <= 1'b0;
            sign      <= 1'b0;
            digit1    <= '0;
            digit2    <= '0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
            dwell_cnt <= '0;
            wait_cnt  <= '0;
            seen      <= 1'b0;
            cap_sign  <= 1'b0;
            cap_big   <= 1'b0;
        end else begin
            state     <= next_state;
            reg_addr  <= nxt_addr;
            lcd_start <= (state != S_PRINT) && (next_state == S_PRINT);
            sign      <= nxt_sign;
            digit1    <= nxt_d1;
            digit2    <= nxt_d2;
            overflow  <= nxt_ovf;
            busy      <= (next_state != S_IDLE);
            dwell_cnt <= nxt_dwell;
            wait_cnt  <= nxt_wait;
            seen      <= nxt_seen;
            cap_sign  <= nxt_cap_sign;
            cap_big   <= nxt_cap_big;
        end
    end

endmodule
